// File: rtl/display_source_arbiter.sv
// Shares one 4-digit display among NUM_SRC producers: timed rotation over enabled
// sources, preempted round-robin by one-shot requests held for HOLD_CYCLES.
module display_source_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100000000,
  parameter int HOLD_CYCLES  = 50000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*16-1:0]      src_value,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic                       freeze,
  output logic [15:0]                binary_num,
  output logic [$clog2(NUM_SRC)-1:0] cur_src,
  output logic [NUM_SRC-1:0]         src_ack,
  output logic                       blank
);

  localparam int IW   = $clog2(NUM_SRC);
  localparam int MAXC = (DWELL_CYCLES > HOLD_CYCLES) ? DWELL_CYCLES : HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ROTATE, HOLD} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] pending;
  logic [IW-1:0]      rot_ptr;
  logic [IW-1:0]      last_grant;
  logic [CW-1:0]      cnt;

  logic               gnt_found;
  logic [IW-1:0]      gnt_idx;
  logic [NUM_SRC-1:0] gnt_mask;
  logic               grant_now;
  logic               rot_found;
  logic [IW-1:0]      rot_next;
  logic [IW-1:0]      low_en;
  logic [15:0]        cur_val;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rot_found = 1'b0;
    rot_next  = rot_ptr;
    low_en    = '0;
    cur_val   = '0;
    // Both searches start one past the pointer and wrap, so i==NUM_SRC revisits the pointer itself.
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!gnt_found && pending[IW'((int'(last_grant) + i) % NUM_SRC)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'((int'(last_grant) + i) % NUM_SRC);
      end
      if (!rot_found && src_en[IW'((int'(rot_ptr) + i) % NUM_SRC)]) begin
        rot_found = 1'b1;
        rot_next  = IW'((int'(rot_ptr) + i) % NUM_SRC);
      end
    end
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (src_en[k]) low_en = IW'(k);
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (cur_src == IW'(k)) cur_val = src_value[16*k +: 16];
    end
    gnt_mask  = NUM_SRC'(1) << gnt_idx;
    grant_now = !freeze && gnt_found && ((state != HOLD) || (cnt == HOLD_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      rot_ptr    <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      cnt        <= '0;
      binary_num <= '0;
      cur_src    <= '0;
      src_ack    <= '0;
      blank      <= 1'b1;
    end else begin
      // A request arriving on its own grant edge is absorbed by the grant.
      pending    <= (pending | src_req) & ~(grant_now ? gnt_mask : '0);
      src_ack    <= grant_now ? gnt_mask : '0;
      binary_num <= blank ? 16'h0000 : cur_val;
      if (grant_now) begin
        state      <= HOLD;
        cur_src    <= gnt_idx;
        last_grant <= gnt_idx;
        cnt        <= '0;
        blank      <= 1'b0;
      end else if (!freeze) begin
        case (state)
          IDLE: begin
            if (|src_en) begin
              state   <= ROTATE;
              cur_src <= low_en;
              rot_ptr <= low_en;
              cnt     <= '0;
              blank   <= 1'b0;
            end
          end
          ROTATE: begin
            if (!(|src_en)) begin
              state <= IDLE;
              cnt   <= '0;
              blank <= 1'b1;
            end else if (!src_en[rot_ptr] || (cnt == DWELL_LAST)) begin
              rot_ptr <= rot_next;
              cur_src <= rot_next;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt <= '0;
              if (|src_en) begin
                state   <= ROTATE;
                cur_src <= rot_ptr;
              end else begin
                state <= IDLE;
                blank <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
